// File: rtl/conv_layer_scheduler.sv
// Per-layer filter sequencer: loads kernel weights, arms the address generator,
// waits for end-of-image, drains the MAC pipe. Optional RUN watchdog: SCHED_TIMEOUT_EN.
module conv_layer_scheduler #(
  parameter int NUM_FILTERS    = 8,
  parameter int KERNEL_WORDS   = 9,
  parameter int PIPE_LATENCY   = 4,
  parameter int WADDR_W        = 12,
  parameter int TIMEOUT_CYCLES = 8191
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               layer_start,
  input  logic               agen_finished,
  output logic               agen_start,
  output logic               weight_load,
  output logic [WADDR_W-1:0] weight_addr,
  output logic [5:0]         filter_idx,
  output logic               acc_clear,
  output logic               conv_en,
  output logic               busy,
  output logic               layer_done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, LOAD_W, ARM, RUN, DRAIN, NEXT, DONE} state_t;

  localparam logic [7:0]         K_LAST = 8'(KERNEL_WORDS - 1);
  localparam logic [5:0]         F_LAST = 6'(NUM_FILTERS - 1);
  localparam logic [3:0]         D_INIT = 4'(PIPE_LATENCY - 1);
  localparam logic [WADDR_W-1:0] KW     = WADDR_W'(KERNEL_WORDS);

  // Elaboration-time range checks on the configuration.
  if (NUM_FILTERS < 1 || NUM_FILTERS > 64 || KERNEL_WORDS < 1 || KERNEL_WORDS > 256 ||
      PIPE_LATENCY < 1 || PIPE_LATENCY > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191 ||
      NUM_FILTERS * KERNEL_WORDS > (1 << WADDR_W)) begin : g_bad_cfg
    $error("conv_layer_scheduler: parameter out of range");
  end

  state_t             state;
  logic [7:0]         k;
  logic [3:0]         dcnt;
  logic [WADDR_W-1:0] base;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wdog;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      dcnt        <= '0;
      base        <= '0;
      filter_idx  <= '0;
      weight_addr <= '0;
      agen_start  <= 1'b0;
      weight_load <= 1'b0;
      acc_clear   <= 1'b0;
      conv_en     <= 1'b0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wdog        <= '0;
      err         <= 1'b0;
`endif
    end else begin
      agen_start <= 1'b0;
      acc_clear  <= 1'b0;
      layer_done <= 1'b0;
      case (state)
        IDLE: if (layer_start) begin
          state       <= LOAD_W;
          filter_idx  <= '0;
          k           <= '0;
          base        <= '0;
          weight_addr <= '0;
          weight_load <= 1'b1;
          busy        <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
          err         <= 1'b0;
`endif
        end
        LOAD_W: if (k == K_LAST) begin
          state       <= ARM;
          weight_load <= 1'b0;
          agen_start  <= 1'b1;
          acc_clear   <= 1'b1;
        end else begin
          k           <= k + 8'd1;
          weight_addr <= base + WADDR_W'(k + 8'd1);
        end
        // agen_finished may still be high from the previous filter; not looked at here.
        ARM: begin
          state   <= RUN;
          conv_en <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
          wdog    <= '0;
`endif
        end
        RUN: if (agen_finished) begin
          state <= DRAIN;
          dcnt  <= D_INIT;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wdog == WD_LAST) begin
          state      <= DONE;
          conv_en    <= 1'b0;
          layer_done <= 1'b1;
          err        <= 1'b1;
        end else begin
          wdog <= wdog + 13'd1;
        end
`endif
        DRAIN: if (dcnt == 4'd0) begin
          state   <= NEXT;
          conv_en <= 1'b0;
        end else begin
          dcnt <= dcnt - 4'd1;
        end
        NEXT: if (filter_idx == F_LAST) begin
          state      <= DONE;
          layer_done <= 1'b1;
        end else begin
          state       <= LOAD_W;
          filter_idx  <= filter_idx + 6'd1;
          base        <= base + KW;
          weight_addr <= base + KW;
          k           <= '0;
          weight_load <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench: 2-filter/9-word/4-deep instance plus a 1/1/1 instance for single-cycle states.
module tb_conv_layer_scheduler;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        layer_start = 1'b0, agen_finished = 1'b0;
  logic        agen_start, weight_load, acc_clear, conv_en, busy, layer_done, err;
  logic [11:0] weight_addr;
  logic [5:0]  filter_idx;

  logic        s_start = 1'b0, s_fin = 1'b0;
  logic        s_agen, s_wl, s_acc, s_conv, s_busy, s_done, s_err;
  logic [3:0]  s_addr;
  logic [5:0]  s_fidx;

  int total = 0, bad = 0;
  int busy_cyc = 0, start_cnt = 0, done_cnt = 0;

  conv_layer_scheduler #(.NUM_FILTERS(2), .KERNEL_WORDS(9), .PIPE_LATENCY(4), .WADDR_W(12),
                         .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .layer_start(layer_start), .agen_finished(agen_finished),
    .agen_start(agen_start), .weight_load(weight_load), .weight_addr(weight_addr),
    .filter_idx(filter_idx), .acc_clear(acc_clear), .conv_en(conv_en), .busy(busy),
    .layer_done(layer_done), .err(err));

  conv_layer_scheduler #(.NUM_FILTERS(1), .KERNEL_WORDS(1), .PIPE_LATENCY(1), .WADDR_W(4),
                         .TIMEOUT_CYCLES(50)) dut1 (
    .clk(clk), .rst_n(rst_n), .layer_start(s_start), .agen_finished(s_fin),
    .agen_start(s_agen), .weight_load(s_wl), .weight_addr(s_addr),
    .filter_idx(s_fidx), .acc_clear(s_acc), .conv_en(s_conv), .busy(s_busy),
    .layer_done(s_done), .err(s_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy)       busy_cyc++;
    if (agen_start) start_cnt++;
    if (layer_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer();
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    total++;
    if (busy !== 1'b1 || weight_load !== 1'b1 || weight_addr !== 12'd0 || filter_idx !== 6'd0 ||
        err !== 1'b0) begin
      bad++;
      $display("FAIL accept: busy=%b wl=%b addr=%0d fidx=%0d err=%b, want 1 1 0 0 0",
               busy, weight_load, weight_addr, filter_idx, err);
    end
  endtask

  // Entered in the first LOAD_W cycle of filter f; leaves in LOAD_W of the next filter or DONE.
  task automatic run_filter(input int f, input int runlen, input bit held, input bit poke);
    if (held) agen_finished = 1'b1;
    for (int k = 0; k < 9; k++) begin
      total++;
      if (weight_load !== 1'b1 || weight_addr !== 12'(f * 9 + k) || filter_idx !== 6'(f) ||
          conv_en !== 1'b0) begin
        bad++;
        $display("FAIL load f%0d k%0d: wl=%b addr=%0d fidx=%0d conv=%b, want 1 %0d %0d 0",
                 f, k, weight_load, weight_addr, filter_idx, conv_en, f * 9 + k, f);
      end
      tick();
    end
    total++;
    if (agen_start !== 1'b1 || acc_clear !== 1'b1 || weight_load !== 1'b0 || conv_en !== 1'b0) begin
      bad++;
      $display("FAIL arm f%0d: start=%b clr=%b wl=%b conv=%b, want 1 1 0 0",
               f, agen_start, acc_clear, weight_load, conv_en);
    end
    tick();
    for (int r = 1; r <= runlen; r++) begin
      total++;
      if (conv_en !== 1'b1 || agen_start !== 1'b0 || acc_clear !== 1'b0 ||
          filter_idx !== 6'(f) || weight_addr !== 12'(f * 9 + 8)) begin
        bad++;
        $display("FAIL run f%0d r%0d: conv=%b start=%b clr=%b fidx=%0d addr=%0d, want 1 0 0 %0d %0d",
                 f, r, conv_en, agen_start, acc_clear, filter_idx, weight_addr, f, f * 9 + 8);
      end
      if (poke && r == 2) layer_start = 1'b1;
      if (r == runlen) agen_finished = 1'b1;
      tick();
      layer_start = 1'b0;
    end
    agen_finished = 1'b0;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (conv_en !== 1'b1 || busy !== 1'b1 || weight_load !== 1'b0) begin
        bad++;
        $display("FAIL drain f%0d d%0d: conv=%b busy=%b wl=%b, want 1 1 0",
                 f, d, conv_en, busy, weight_load);
      end
      tick();
    end
    total++;
    if (conv_en !== 1'b0 || busy !== 1'b1 || weight_load !== 1'b0 || layer_done !== 1'b0) begin
      bad++;
      $display("FAIL next f%0d: conv=%b busy=%b wl=%b done=%b, want 0 1 0 0",
               f, conv_en, busy, weight_load, layer_done);
    end
    tick();
  endtask

  task automatic finish_layer(input string name);
    total++;
    if (layer_done !== 1'b1 || busy !== 1'b1 || conv_en !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b busy=%b conv=%b, want 1 1 0", name, layer_done, busy, conv_en);
    end
    tick();
    total++;
    if (layer_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: done=%b busy=%b, want 0 0", name, layer_done, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({agen_start, weight_load, weight_addr, filter_idx, acc_clear, conv_en, busy, layer_done, err,
         s_agen, s_wl, s_addr, s_fidx, s_acc, s_conv, s_busy, s_done, s_err} !== '0) begin
      bad++;
      $display("FAIL reset: outputs=%b, want all 0",
               {agen_start, weight_load, weight_addr, filter_idx, acc_clear, conv_en, busy, layer_done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_layer();
    int b0, s0, d0;
    b0 = busy_cyc; s0 = start_cnt; d0 = done_cnt;
    start_layer();
    run_filter(0, 20, 1'b0, 1'b0);
    run_filter(1, 20, 1'b0, 1'b0);
    finish_layer("layer");
    total++;
    if (busy_cyc - b0 != 71 || start_cnt - s0 != 2 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL layer counts: busy=%0d starts=%0d dones=%0d, want 71 2 1",
               busy_cyc - b0, start_cnt - s0, done_cnt - d0);
    end
    tick();
  endtask

  task automatic test_finished_held();
    start_layer();
    run_filter(0, 1, 1'b1, 1'b0);
    run_filter(1, 1, 1'b1, 1'b0);
    finish_layer("held");
    tick();
  endtask

  task automatic test_start_ignored();
    int d0;
    d0 = done_cnt;
    start_layer();
    run_filter(0, 5, 1'b0, 1'b1);
    run_filter(1, 5, 1'b0, 1'b1);
    finish_layer("ignore");
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL ignore dones: got %0d, want 1", done_cnt - d0);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start_layer();
    run_filter(0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    agen_finished = 1'b1;
    tick();
    agen_finished = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({agen_start, weight_load, weight_addr, filter_idx, acc_clear, conv_en, busy, layer_done,
         err} !== '0) begin
      bad++;
      $display("FAIL mid reset: conv=%b busy=%b fidx=%0d addr=%0d, want all 0",
               conv_en, busy, filter_idx, weight_addr);
    end
    #2 rst_n = 1'b1;
    tick();
    start_layer();
    run_filter(0, 2, 1'b0, 1'b0);
    run_filter(1, 2, 1'b0, 1'b0);
    finish_layer("restart");
    tick();
  endtask

  task automatic test_min_config();
    logic [3:0] exp_seq [6];
    exp_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({s_wl, s_agen, s_conv, s_done} !== exp_seq[i] || s_busy !== 1'b1 || s_addr !== 4'd0) begin
        bad++;
        $display("FAIL min step%0d: {wl,start,conv,done}=%b busy=%b addr=%0d, want %b 1 0",
                 i, {s_wl, s_agen, s_conv, s_done}, s_busy, s_addr, exp_seq[i]);
      end
      if (i == 1) s_fin = 1'b1;
      if (i == 3) s_fin = 1'b0;
      tick();
    end
    total++;
    if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      bad++;
      $display("FAIL min idle: busy=%b done=%b, want 0 0", s_busy, s_done);
    end
    tick();
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    start_layer();
    for (int i = 0; i < 10; i++) tick();
    for (int r = 1; r <= 50; r++) begin
      total++;
      if (conv_en !== 1'b1 || layer_done !== 1'b0) begin
        bad++;
        $display("FAIL timeout run r%0d: conv=%b done=%b, want 1 0", r, conv_en, layer_done);
      end
      tick();
    end
    total++;
    if (layer_done !== 1'b1 || err !== 1'b1 || conv_en !== 1'b0) begin
      bad++;
      $display("FAIL timeout done: done=%b err=%b conv=%b, want 1 1 0", layer_done, err, conv_en);
    end
    tick();
    total++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL timeout sticky: busy=%b err=%b, want 0 1", busy, err);
    end
    start_layer();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_layer();
    test_finished_held();
    test_start_ignored();
    test_reset_mid();
    test_min_config();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
